// File: rtl/temp_hyst_pkg.sv
// Shared types and helpers for the multi-channel hysteresis temperature monitor.
package temp_hyst_pkg;

  typedef enum logic [1:0] {
    NORMAL,
    PEND_HOT,
    HOT,
    PEND_COOL
  } hyst_state_t;

  localparam int unsigned DEB_CNT_W = 4;

  // Index width that never collapses to zero for a single-channel build.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/temp_hyst_monitor_channel.sv
// One monitored channel: byte-loaded high/low thresholds and the debounced
// hysteresis FSM that produces the warn flag plus a one-cycle change pulse.
module hyst_channel
  import temp_hyst_pkg::*;
#(
  parameter int unsigned W   = 16,
  parameter int unsigned DEB = 3
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         sample_hit_i,
  input  logic [W-1:0] sample_data_i,
  input  logic         cfg_we_hi_i,
  input  logic         cfg_we_lo_i,
  input  logic [7:0]   cfg_byte_i,
  output logic         warn_o,
  output logic         event_o
);

  localparam logic [DEB_CNT_W-1:0] DEB_C = DEB_CNT_W'(DEB);

  hyst_state_t          state_q;
  logic [DEB_CNT_W-1:0] cnt_q;
  logic [DEB_CNT_W-1:0] cnt_inc;
  logic [W-1:0]         thr_hi_q;
  logic [W-1:0]         thr_lo_q;
  logic                 warn_q;
  logic                 event_q;
  logic [W+7:0]         hi_shift;
  logic [W+7:0]         lo_shift;
  logic                 over_hi;
  logic                 under_lo;

  // New byte enters at the top, so an LSB-first burst of W/8 bytes replaces the register.
  assign hi_shift = {cfg_byte_i, thr_hi_q};
  assign lo_shift = {cfg_byte_i, thr_lo_q};
  assign cnt_inc  = cnt_q + DEB_CNT_W'(1);
  assign over_hi  = sample_data_i > thr_hi_q;
  assign under_lo = sample_data_i < thr_lo_q;
  assign warn_o   = warn_q;
  assign event_o  = event_q;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q  <= NORMAL;
      cnt_q    <= '0;
      thr_hi_q <= '1;
      thr_lo_q <= '0;
      warn_q   <= 1'b0;
      event_q  <= 1'b0;
    end else begin
      event_q <= 1'b0;
      if (cfg_we_hi_i) thr_hi_q <= hi_shift[W+7:8];
      if (cfg_we_lo_i) thr_lo_q <= lo_shift[W+7:8];
      if (sample_hit_i) begin
        unique case (state_q)
          NORMAL: begin
            if (over_hi) begin
              if (DEB == 1) begin
                state_q <= HOT;
                warn_q  <= 1'b1;
                event_q <= 1'b1;
              end else begin
                state_q <= PEND_HOT;
                cnt_q   <= DEB_CNT_W'(1);
              end
            end
          end
          PEND_HOT: begin
            if (over_hi) begin
              if (cnt_inc == DEB_C) begin
                state_q <= HOT;
                cnt_q   <= '0;
                warn_q  <= 1'b1;
                event_q <= 1'b1;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              state_q <= NORMAL;
              cnt_q   <= '0;
            end
          end
          HOT: begin
            if (under_lo) begin
              if (DEB == 1) begin
                state_q <= NORMAL;
                warn_q  <= 1'b0;
                event_q <= 1'b1;
              end else begin
                state_q <= PEND_COOL;
                cnt_q   <= DEB_CNT_W'(1);
              end
            end
          end
          PEND_COOL: begin
            if (under_lo) begin
              if (cnt_inc == DEB_C) begin
                state_q <= NORMAL;
                cnt_q   <= '0;
                warn_q  <= 1'b0;
                event_q <= 1'b1;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              state_q <= HOT;
              cnt_q   <= '0;
            end
          end
          default: begin
            state_q <= NORMAL;
            cnt_q   <= '0;
            warn_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/temp_hyst_monitor.sv
// Multi-channel hysteresis temperature monitor: channel decode, event encoder
// and optional sticky alarms (enabled by defining STICKY_ALARM_EN).
module temp_hyst_monitor
  import temp_hyst_pkg::*;
#(
  parameter  int unsigned W   = 16,
  parameter  int unsigned NCH = 2,
  parameter  int unsigned DEB = 3,
  localparam int unsigned CHW = clog2_min1(NCH)
) (
  input  logic           clk_in,
  input  logic           rst_n,
  input  logic           sample_valid,
  input  logic [CHW-1:0] sample_ch,
  input  logic [W-1:0]   sample_data,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic           cfg_sel,
  input  logic [7:0]     cfg_byte,
  output logic [NCH-1:0] warn,
  output logic           warn_event,
  output logic [CHW-1:0] event_ch,
  output logic           event_rise,
  output logic [NCH-1:0] sticky,
  input  logic [NCH-1:0] sticky_clr
);

  logic [NCH-1:0] ch_event;
  logic [CHW-1:0] ev_ch_enc;
  logic           ev_rise_now;
  logic [CHW-1:0] last_ch_q;
  logic           last_rise_q;

  // Out-of-range channel indices simply match no instance.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic hit;
    logic we_hi;
    logic we_lo;

    assign hit   = sample_valid && (sample_ch == CHW'(g));
    assign we_hi = cfg_we && !cfg_sel && (cfg_ch == CHW'(g));
    assign we_lo = cfg_we &&  cfg_sel && (cfg_ch == CHW'(g));

    hyst_channel #(
      .W   (W),
      .DEB (DEB)
    ) u_ch (
      .clk_in        (clk_in),
      .rst_n         (rst_n),
      .sample_hit_i  (hit),
      .sample_data_i (sample_data),
      .cfg_we_hi_i   (we_hi),
      .cfg_we_lo_i   (we_lo),
      .cfg_byte_i    (cfg_byte),
      .warn_o        (warn[g]),
      .event_o       (ch_event[g])
    );
  end

  always_comb begin
    ev_ch_enc = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (ch_event[i]) ev_ch_enc = CHW'(i);
    end
  end

  // At most one channel changes per cycle, so the OR-reduction is unambiguous.
  assign ev_rise_now = |(ch_event & warn);
  assign warn_event  = |ch_event;
  assign event_ch    = warn_event ? ev_ch_enc : last_ch_q;
  assign event_rise  = warn_event ? ev_rise_now : last_rise_q;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      last_ch_q   <= '0;
      last_rise_q <= 1'b0;
    end else if (warn_event) begin
      last_ch_q   <= ev_ch_enc;
      last_rise_q <= ev_rise_now;
    end
  end

`ifdef STICKY_ALARM_EN
  logic [NCH-1:0] sticky_q;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= (sticky_q & ~sticky_clr) | (ch_event & warn);
    end
  end

  assign sticky = sticky_q;
`else
  logic [NCH-1:0] unused_sticky_clr;

  assign unused_sticky_clr = sticky_clr;
  assign sticky            = '0;
`endif

endmodule
